// File: rtl/rv32i_types.sv
// Shared typedefs and default widths for the memory-side cache plumbing.
package rv32i_types;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// Two-way round-robin pick between icache and dcache requests.
// Ties go to the side that was not granted last.
module rr_arb2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic grant_i,
  output logic grant_d
);

  // d wins a tie only when i was the most recent grant
  always_comb begin
    grant_d = req_d & (~req_i | ~last_d);
    grant_i = req_i & ~grant_d;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cacheline memory port between the icache (read) and dcache
// (read/write). One miss in flight at a time; the grant is held until memory
// responds, then a one-cycle DONE gap lets the requester drop its request.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              dwr_q, dwr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic req_d, grant_i, grant_d;

  // d_write alone marks a writeback; d_read|d_write both count as a dcache request
  assign req_d = d_read | d_write;

  rr_arb2 u_rr (
    .req_i   (i_read),
    .req_d   (req_d),
    .last_d  (last_d_q),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Fill data is a straight passthrough; consumers qualify it with *_resp
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Next-state, capture and output decode
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    dwr_d     = dwr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          dwr_d    = d_write;   // write wins if both asserted
        end else if (grant_i) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = i_addr;
          dwr_d    = 1'b0;
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_d = DONE;
        end
      end
      SERVE_D: begin
        mem_read  = ~dwr_q;
        mem_write = dwr_q;
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset aborts any in-flight request
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      dwr_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      dwr_q    <= dwr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, lone ifetch, contention order,
// writeback capture, reset mid-serve and stray memory responses.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_addr;

  int vec  = 0;
  int miss = 0;

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [LW-1:0] w1, r1, ra5;
  bit            exp_d;

  initial begin
    w1  = {8{32'h1234_5678}};
    r1  = {8{32'hCAFE_0001}};
    ra5 = {32{8'hA5}};
    rst = 1'b0; i_read = 1'b1; d_read = 1'b0; d_write = 1'b1;
    i_addr = 32'h40; d_addr = 32'h2000; d_wdata = r1; mem_rdata = '0; mem_resp = 1'b0;

    // reset held with requests pending
    repeat (3) begin
      tick();
      chk("rst_mem_read",  LW'(mem_read),  '0);
      chk("rst_mem_write", LW'(mem_write), '0);
      chk("rst_i_resp",    LW'(i_resp),    '0);
      chk("rst_d_resp",    LW'(d_resp),    '0);
      chk("rst_mem_addr",  LW'(mem_addr),  '0);
      chk("rst_mem_wdata", mem_wdata,      '0);
    end
    rst = 1'b1;
    tick();  // IDLE grants d (last_d=0)
    chk("rel_mem_write", LW'(mem_write), LW'(1));
    chk("rel_mem_read",  LW'(mem_read),  '0);
    chk("rel_mem_addr",  LW'(mem_addr),  LW'(32'h2000));
    mem_resp = 1'b1; mem_rdata = r1; #1;
    chk("rel_d_resp", LW'(d_resp), LW'(1));
    chk("rel_i_resp", LW'(i_resp), '0);
    tick();  // DONE
    d_write = 1'b0; i_read = 1'b0; mem_resp = 1'b0;
    chk("rel_done_write", LW'(mem_write), '0);
    chk("rel_done_resp",  LW'(d_resp),    '0);
    tick();  // IDLE

    // lone ifetch
    i_read = 1'b1; i_addr = 32'h60;
    tick();
    chk("if_mem_read",  LW'(mem_read),  LW'(1));
    chk("if_mem_write", LW'(mem_write), '0);
    chk("if_mem_addr",  LW'(mem_addr),  LW'(32'h60));
    repeat (3) begin
      tick();
      chk("if_wait_resp", LW'(i_resp), '0);
    end
    tick();
    mem_resp = 1'b1; mem_rdata = ra5; #1;
    chk("if_i_resp",  LW'(i_resp), LW'(1));
    chk("if_i_rdata", i_rdata,     ra5);
    chk("if_d_resp",  LW'(d_resp), '0);
    tick();  // DONE
    i_read = 1'b0; mem_resp = 1'b0;
    chk("if_done_read", LW'(mem_read), '0);
    chk("if_done_resp", LW'(i_resp),   '0);
    tick();  // IDLE

    // contention: last grant was i, so order is D,I,D,I
    i_addr = 32'h80; d_addr = 32'h3000;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      tick();
      chk("ct_mem_read", LW'(mem_read), LW'(1));
      chk("ct_mem_addr", LW'(mem_addr), exp_d ? LW'(32'h3000) : LW'(32'h80));
      mem_resp = 1'b1; #1;
      chk("ct_i_resp", LW'(i_resp), LW'(!exp_d));
      chk("ct_d_resp", LW'(d_resp), LW'(exp_d));
      tick();  // DONE gap
      mem_resp = 1'b0;
      if (exp_d) d_read = 1'b0; else i_read = 1'b0;
      chk("ct_gap_read", LW'(mem_read), '0);
      tick();  // IDLE
      i_read = 1'b1; d_read = 1'b1;
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();  // stays IDLE, nothing requested
    chk("ct_idle_read", LW'(mem_read), '0);

    // writeback with wdata changing after grant
    d_write = 1'b1; d_addr = 32'h1000; d_wdata = w1;
    tick();
    d_wdata = ~w1;
    chk("wb_mem_write", LW'(mem_write), LW'(1));
    chk("wb_mem_read",  LW'(mem_read),  '0);
    chk("wb_mem_addr",  LW'(mem_addr),  LW'(32'h1000));
    chk("wb_mem_wdata", mem_wdata,      w1);
    tick();
    chk("wb_wdata_held", mem_wdata, w1);
    mem_resp = 1'b1; #1;
    chk("wb_d_resp", LW'(d_resp), LW'(1));
    chk("wb_i_resp", LW'(i_resp), '0);
    tick();  // DONE
    d_write = 1'b0; mem_resp = 1'b0;
    tick();  // IDLE

    // reset mid-serve, then stray mem_resp while idle
    d_write = 1'b1; d_addr = 32'h4000;
    tick();
    chk("ms_mem_write", LW'(mem_write), LW'(1));
    rst = 1'b0;
    tick();
    chk("ms_abort_write", LW'(mem_write), '0);
    chk("ms_abort_resp",  LW'(d_resp),    '0);
    chk("ms_abort_addr",  LW'(mem_addr),  '0);
    d_write = 1'b0; rst = 1'b1;
    tick();
    mem_resp = 1'b1; #1;
    chk("stray_i_resp", LW'(i_resp), '0);
    chk("stray_d_resp", LW'(d_resp), '0);
    tick();
    mem_resp = 1'b0;
    chk("stray_mem_read",  LW'(mem_read),  '0);
    chk("stray_mem_write", LW'(mem_write), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
